ptw_nlevel_arb: RTL

Parametrised N-level page-table walker shared by ITLB and DTLB. It arbitrates round-robin between the two miss channels and walks LEVELS radix levels from a run-time root PPN. It checks PTE valid and leaf bits, returning either a translated PPN or a fault. It sits between both TLBs and the shared word-level memory port, yields to the dcache via MEM_stall, and supports a flush that aborts walks cleanly.

---
 rtl/ptw_pkg.sv | 32 +++
 rtl/ptw_req_arb.sv | 66 ++++++
 rtl/ptw_nlevel_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ptw_pkg.sv
// Shared definitions for the page-table walker: FSM states, channel ids and
// PTE field decoding helpers.
package ptw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StResp,
    StDrain
  } ptw_state_e;

  localparam logic ChanItlb = 1'b0;
  localparam logic ChanDtlb = 1'b1;

  localparam int unsigned PteWidth  = 32;
  localparam int unsigned PteVBit   = 0;
  localparam int unsigned PteRBit   = 1;
  localparam int unsigned PteWBit   = 2;
  localparam int unsigned PteXBit   = 3;
  localparam int unsigned PtePpnLsb = 12;

  function automatic logic pte_is_leaf(logic [PteWidth-1:0] pte);
    return pte[PteRBit] | pte[PteWBit] | pte[PteXBit];
  endfunction

  // Caller truncates to its own PPN width.
  function automatic logic [PteWidth-1:0] pte_ppn(logic [PteWidth-1:0] pte);
    return pte >> PtePpnLsb;
  endfunction

endpackage

// File: rtl/ptw_req_arb.sv
// Miss-request capture for the ITLB/DTLB channels: one pending flag and VPN
// latch per channel plus a round-robin pick when both are waiting.
module ptw_req_arb
  import ptw_pkg::*;
#(
  parameter int unsigned VPN_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 itlb_req_i,
  input  logic [VPN_WIDTH-1:0] itlb_vpn_i,
  input  logic                 dtlb_req_i,
  input  logic [VPN_WIDTH-1:0] dtlb_vpn_i,
  input  logic                 grant_i,
  input  logic                 clr_i,
  input  logic                 clr_sel_i,
  output logic                 pending_o,
  output logic                 sel_o,
  output logic [VPN_WIDTH-1:0] sel_vpn_o
);

  logic [1:0]           pend_q, pend_d;
  logic [VPN_WIDTH-1:0] ivpn_q, ivpn_d;
  logic [VPN_WIDTH-1:0] dvpn_q, dvpn_d;
  logic                 rr_q, rr_d;
  logic [1:0]           req;
  logic [1:0]           clr_vec;
  logic [1:0]           set_vec;

  assign req     = {dtlb_req_i, itlb_req_i};
  assign clr_vec = {clr_i && (clr_sel_i == ChanDtlb), clr_i && (clr_sel_i == ChanItlb)};
  // A request is taken when idle or when its flag is being cleared this cycle.
  assign set_vec = req & (~pend_q | clr_vec) & {2{~flush_i}};

  always_comb begin
    pend_d = flush_i ? 2'b00 : ((pend_q & ~clr_vec) | set_vec);
    ivpn_d = set_vec[0] ? itlb_vpn_i : ivpn_q;
    dvpn_d = set_vec[1] ? dtlb_vpn_i : dvpn_q;
    rr_d   = rr_q;
    // Pointer only advances on a contested grant, so a lone request never
    // steals the other channel's turn.
    if (grant_i && (&pend_q)) begin
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 2'b00;
      ivpn_q <= '0;
      dvpn_q <= '0;
      rr_q   <= ChanItlb;
    end else begin
      pend_q <= pend_d;
      ivpn_q <= ivpn_d;
      dvpn_q <= dvpn_d;
      rr_q   <= rr_d;
    end
  end

  assign pending_o = |pend_q;
  assign sel_o     = (&pend_q) ? rr_q : pend_q[1];
  assign sel_vpn_o = sel_o ? dvpn_q : ivpn_q;

endmodule

// File: rtl/ptw_nlevel_arb.sv
// Shared N-level page-table walker for ITLB and DTLB misses, walking from a
// run-time root PPN over a word-level memory port shared with the dcache.
module ptw_nlevel_arb
  import ptw_pkg::*;
#(
  parameter int unsigned VA_WIDTH          = 32,
  parameter int unsigned PC_BITS           = 20,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned LEVELS            = 2,
  parameter int unsigned IDX_WIDTH         = 10,
  parameter int unsigned PTE_BYTES_LOG2    = 2,
  localparam int unsigned VPN_WIDTH        = VA_WIDTH - PAGE_OFFSET_WIDTH,
  localparam int unsigned PPN_WIDTH        = PC_BITS - PAGE_OFFSET_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PPN_WIDTH-1:0] Root_ppn,
  input  logic                 Ptw_flush,
  input  logic                 Itlb_pa_request,
  input  logic [VPN_WIDTH-1:0] Itlb_va,
  output logic                 F_ptw_valid,
  output logic [PPN_WIDTH-1:0] F_ptw_pa,
  output logic                 F_ptw_fault,
  input  logic                 Dtlb_pa_request,
  input  logic [VPN_WIDTH-1:0] Dtlb_va,
  output logic                 M_ptw_valid,
  output logic [PPN_WIDTH-1:0] M_ptw_pa,
  output logic                 M_ptw_fault,
  output logic                 Ptw_mem_req,
  output logic [PC_BITS-1:0]   Ptw_mem_addr,
  input  logic [31:0]          Ptw_mem_rdata,
  input  logic                 Ptw_mem_valid,
  input  logic                 MEM_stall,
  output logic                 Ptw_busy
);

  localparam int unsigned LvlW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  ptw_state_e           state_q, state_d;
  logic                 chan_q, chan_d;
  logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
  logic [PPN_WIDTH-1:0] ppn_q, ppn_d;
  logic [LvlW-1:0]      lvl_q, lvl_d;
  logic [PPN_WIDTH-1:0] res_ppn_q, res_ppn_d;
  logic                 res_fault_q, res_fault_d;

  logic                 arb_pending;
  logic                 arb_sel;
  logic [VPN_WIDTH-1:0] arb_vpn;
  logic                 grant;
  logic                 clr;

  logic                 pte_v;
  logic                 pte_leaf;
  logic [PteWidth-1:0]  pte_ppn_full;
  logic [PPN_WIDTH-1:0] pte_ppn_w;
  logic                 lvl_is_zero;
  logic [IDX_WIDTH-1:0] cur_idx;
  logic                 unused_pte_ppn;

  ptw_req_arb #(
    .VPN_WIDTH(VPN_WIDTH)
  ) u_req_arb (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (Ptw_flush),
    .itlb_req_i(Itlb_pa_request),
    .itlb_vpn_i(Itlb_va),
    .dtlb_req_i(Dtlb_pa_request),
    .dtlb_vpn_i(Dtlb_va),
    .grant_i   (grant),
    .clr_i     (clr),
    .clr_sel_i (chan_q),
    .pending_o (arb_pending),
    .sel_o     (arb_sel),
    .sel_vpn_o (arb_vpn)
  );

  assign pte_v          = Ptw_mem_rdata[PteVBit];
  assign pte_leaf       = pte_is_leaf(Ptw_mem_rdata);
  assign pte_ppn_full   = pte_ppn(Ptw_mem_rdata);
  assign pte_ppn_w      = pte_ppn_full[PPN_WIDTH-1:0];
  assign unused_pte_ppn = ^pte_ppn_full;
  assign lvl_is_zero    = (lvl_q == '0);
  assign cur_idx        = vpn_q[lvl_q*IDX_WIDTH +: IDX_WIDTH];

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    vpn_d       = vpn_q;
    ppn_d       = ppn_q;
    lvl_d       = lvl_q;
    res_ppn_d   = res_ppn_q;
    res_fault_d = res_fault_q;
    grant       = 1'b0;
    clr         = 1'b0;
    Ptw_mem_req = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_pending && !Ptw_flush) begin
          grant   = 1'b1;
          chan_d  = arb_sel;
          vpn_d   = arb_vpn;
          ppn_d   = Root_ppn;
          lvl_d   = LvlW'(LEVELS - 1);
          state_d = StReq;
        end
      end
      StReq: begin
        if (Ptw_flush) begin
          state_d = StIdle;
        end else if (!MEM_stall) begin
          Ptw_mem_req = 1'b1;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (Ptw_flush) begin
          state_d = Ptw_mem_valid ? StIdle : StDrain;
        end else if (Ptw_mem_valid) begin
          // Leaves are only legal at level 0 and level 0 must be a leaf.
          if (!pte_v || (pte_leaf != lvl_is_zero)) begin
            res_fault_d = 1'b1;
            res_ppn_d   = '0;
            state_d     = StResp;
          end else if (pte_leaf) begin
            res_fault_d = 1'b0;
            res_ppn_d   = pte_ppn_w;
            state_d     = StResp;
          end else begin
            ppn_d   = pte_ppn_w;
            lvl_d   = lvl_q - 1'b1;
            state_d = StReq;
          end
        end
      end
      StResp: begin
        clr     = 1'b1;
        state_d = StIdle;
      end
      StDrain: begin
        if (Ptw_mem_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      chan_q      <= ChanItlb;
      vpn_q       <= '0;
      ppn_q       <= '0;
      lvl_q       <= '0;
      res_ppn_q   <= '0;
      res_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      vpn_q       <= vpn_d;
      ppn_q       <= ppn_d;
      lvl_q       <= lvl_d;
      res_ppn_q   <= res_ppn_d;
      res_fault_q <= res_fault_d;
    end
  end

  always_comb begin
    Ptw_mem_addr = '0;
    if (state_q == StReq) begin
      Ptw_mem_addr = {ppn_q, cur_idx, {PTE_BYTES_LOG2{1'b0}}};
    end
    F_ptw_valid = (state_q == StResp) && (chan_q == ChanItlb);
    M_ptw_valid = (state_q == StResp) && (chan_q == ChanDtlb);
    F_ptw_pa    = F_ptw_valid ? res_ppn_q : '0;
    M_ptw_pa    = M_ptw_valid ? res_ppn_q : '0;
    F_ptw_fault = F_ptw_valid && res_fault_q;
    M_ptw_fault = M_ptw_valid && res_fault_q;
    Ptw_busy    = (state_q != StIdle);
  end

endmodule
